// File: rtl/mmio_write_fifo.sv
// -----------------------------------------------------------------------------
// mmio_write_fifo
//
// Watches the data-memory write bus of the single-cycle computer and captures
// every store to MMIO_ADDR into a small first-word-fall-through FIFO. The
// captured words go to a downstream sink (display, UART driver, bench
// observer), so program output can be seen without probing data memory.
//
// Parameters:
//   WIDTH      bit width of writedata, dataadr and out_data
//   DEPTH      FIFO entries (power of two, >= 2)
//   MMIO_ADDR  store address that is captured
//
// Ports:
//   clk           system clock, all state updates on the rising edge
//   reset         asynchronous, active-high reset
//   memwrite      store strobe from the computer
//   dataadr       store address from the computer
//   writedata     store data from the computer
//   clear         synchronous flush of FIFO contents and overflow flag
//   out_valid     FIFO head holds a word
//   out_data      FIFO head word (0 while empty)
//   out_ready     sink accepts the head word this cycle
//   count         current occupancy, 0..DEPTH
//   full          count == DEPTH
//   empty         count == 0
//   overflow      sticky: a matching store was dropped because the FIFO was full
//
// Optional build macro MMIO_FIFO_STATS_EN adds:
//   accepted_cnt  saturating count of stores written into the FIFO
//   dropped_cnt   saturating count of stores dropped while full
//
// Handshake: a word transfers on a rising edge where out_valid && out_ready
// are both 1. out_valid and out_data depend only on registered state; the
// sink may drive out_ready at any time, and out_ready while out_valid is 0
// has no effect.
// -----------------------------------------------------------------------------
module mmio_write_fifo #(
   parameter int               WIDTH     = 16,
   parameter int               DEPTH     = 8,
   parameter logic [WIDTH-1:0] MMIO_ADDR = 16'd84
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     memwrite,
   input  logic [WIDTH-1:0]         dataadr,
   input  logic [WIDTH-1:0]         writedata,
   input  logic                     clear,
   output logic                     out_valid,
   output logic [WIDTH-1:0]         out_data,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   output logic                     overflow
`ifdef MMIO_FIFO_STATS_EN
   ,
   output logic [15:0]              accepted_cnt,
   output logic [15:0]              dropped_cnt
`endif
);

   localparam int            AW      = $clog2(DEPTH);
   localparam int            CW      = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;

   logic push;     // matching store seen on the bus this cycle
   logic pop;      // head word handed to the sink this cycle
   logic do_push;  // store actually written into the FIFO
   logic drop;     // store lost because the FIFO is full and nothing leaves

   assign push = memwrite && (dataadr == MMIO_ADDR);
   assign pop  = out_valid && out_ready;

   // A pop frees the head slot on the same edge, so a full FIFO can still
   // accept a store when the sink is draining it.
   assign do_push = push && (!full || pop);
   assign drop    = push && full && !pop;

   assign empty     = (count == '0);
   assign full      = (count == DEPTH_C);
   assign out_valid = !empty;
   assign out_data  = empty ? '0 : mem[rd_ptr];

   // Pointers, occupancy and overflow flag. clear outranks push and pop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else if (clear) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (drop) begin
            overflow <= 1'b1;
         end
      end
   end

   // Storage has no reset; the pointers define which entries are meaningful.
   always_ff @(posedge clk) begin
      if (do_push && !clear) begin
         mem[wr_ptr] <= writedata;
      end
   end

`ifdef MMIO_FIFO_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         accepted_cnt <= '0;
         dropped_cnt  <= '0;
      end else if (clear) begin
         accepted_cnt <= '0;
         dropped_cnt  <= '0;
      end else begin
         if (do_push && (accepted_cnt != 16'hFFFF)) begin
            accepted_cnt <= accepted_cnt + 16'd1;
         end
         if (drop && (dropped_cnt != 16'hFFFF)) begin
            dropped_cnt <= dropped_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: doc/mmio_write_fifo.md
Name: mmio_write_fifo

Overview:
- Downstream consumer of the single-cycle computer's data-memory write bus (writedata, dataadr, memwrite).
- Captures every store to one memory-mapped output address into a small FIFO.
- Presents captured words to a downstream sink, such as a display or UART driver, over a valid/ready handshake.
- Lets benches and hardware observe program output, e.g. the value stored to address 84, without probing data memory.

Parameters:
- WIDTH, 16, bit width of writedata, dataadr and out_data.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- MMIO_ADDR, 16'd84, store address that is captured.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- memwrite  input  1  store strobe from computer.
- dataadr  input  WIDTH  store address from computer.
- writedata  input  WIDTH  store data from computer.
- clear  input  1  synchronous flush of FIFO and overflow flag.
- out_valid  output  1  FIFO head holds a word.
- out_data  output  WIDTH  FIFO head word.
- out_ready  input  1  sink accepts head this cycle.
- count  output  $clog2(DEPTH)+1  current occupancy.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky: a matching store was dropped.

Behaviour:
- Reset is asynchronous and active-high; the block has one clock, clk.
- Reset values: rd_ptr=0, wr_ptr=0, count=0, overflow=0, out_valid=0, empty=1, full=0, out_data=0. Storage array contents are not reset.
- push = memwrite && (dataadr == MMIO_ADDR), sampled at the rising edge. Other addresses, and memwrite=0, are ignored.
- pop = out_valid && out_ready. out_ready while empty has no effect.
- Read side is first-word fall-through:
  - out_data = mem[rd_ptr] when !empty, otherwise 0.
  - out_valid = !empty. Both come from registered state, with no combinational path from the bus inputs.
- Latency: a store captured at edge N appears on out_valid/out_data in the cycle after edge N.
- Push when not full: mem[wr_ptr] <= writedata, wr_ptr increments.
- Pop: rd_ptr increments.
- Pointers wrap modulo DEPTH (natural wrap of $clog2(DEPTH)-bit counters).
- count updates as follows:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop.
- Full boundary:
  - Push with no pop: word is dropped, overflow <= 1, pointers and count unchanged.
  - Push and pop in the same cycle: both occur, no drop, count stays DEPTH.
- Empty boundary: a push in the same cycle as out_ready=1 is not popped that cycle, because out_valid was 0.
- Overflow stays at 1 until reset or clear.
- clear has priority over push and pop in the same cycle. It zeroes pointers, count and overflow; the concurrent push is discarded.
- Reset asserted mid-operation aborts immediately. All outputs return to their reset values asynchronously, regardless of clk.
- Back-to-back stores every cycle are accepted at one per cycle up to DEPTH.

Optional Feature:
- Macro: MMIO_FIFO_STATS_EN.
- Defined:
  - Adds output accepted_cnt [15:0], incremented on each successful push.
  - Adds output dropped_cnt [15:0], incremented on each dropped push.
  - Both saturate at 16'hFFFF.
  - Both reset to 0 on reset and on clear.
- Undefined: neither port nor its counters exist; all other behaviour is identical.

Test Plan:
- Single capture: after reset, memwrite=1, dataadr=84, writedata=16'h0096 for one cycle -> next cycle out_valid=1, out_data=16'h0096, count=1. Then out_ready=1 for one cycle -> empty=1, out_data=0.
- Address filter: stores to addresses 80 and 88 with data 16'h1234, plus memwrite=0 with dataadr=84 -> count stays 0, out_valid stays 0.
- Fill and overflow: 9 consecutive stores to 84 with data 1..9, out_ready=0 -> full=1, count=8, overflow=1. Draining yields 1..8 in order; 9 is never output.
- Full with simultaneous push and pop: FIFO full holding 1..8, then store 16'hAA with out_ready=1 -> overflow stays 0, count=8, drain order 2..8 then 16'hAA.
- Wrap-around: repeat push of 3 words and pop of 3 words over 5 rounds, data incrementing -> output order exactly matches input order, no spurious valid.
- Clear/reset priority:
  - 4 words queued and overflow=1, then clear asserted together with a store of 16'h55 -> count=0, overflow=0, 16'h55 never output.
  - Reset asserted mid-clock-period with 2 words queued -> out_valid falls immediately.
